// File: rtl/axil_cfg_sequencer.sv
// AXI-lite master that walks a parameter-defined register script (write, poll, delay, end)
// after reset or on a start pulse, reporting busy/done/error with the failing entry index.
module axil_cfg_sequencer #(
  parameter int                            DATA_WIDTH = 32,
  parameter int                            ADDR_WIDTH = 16,
  parameter int                            STRB_WIDTH = DATA_WIDTH / 8,
  parameter int                            ENTRIES    = 8,
  parameter logic [2*ENTRIES-1:0]          TABLE_OP   = '0,
  parameter logic [ADDR_WIDTH*ENTRIES-1:0] TABLE_ADDR = '0,
  parameter logic [DATA_WIDTH*ENTRIES-1:0] TABLE_DATA = '0,
  parameter logic [DATA_WIDTH*ENTRIES-1:0] TABLE_MASK = '0,
  parameter int                            POLL_LIMIT = 1024,
  parameter bit                            AUTO_START = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [7:0]            err_index,
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready
);

  localparam int IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam logic [8:0] LAST_IDX = 9'(ENTRIES);
  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_POLL  = 2'd1;
  localparam logic [1:0] OP_DELAY = 2'd2;
  localparam logic [DATA_WIDTH-1:0] ONE_D = DATA_WIDTH'(1);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_WR_REQ  = 4'd2,
    S_WR_RESP = 4'd3,
    S_RD_REQ  = 4'd4,
    S_RD_RESP = 4'd5,
    S_DELAY   = 4'd6,
    S_DONE    = 4'd7,
    S_ERROR   = 4'd8
  } state_t;

  logic [1:0]            op_tab   [ENTRIES];
  logic [ADDR_WIDTH-1:0] addr_tab [ENTRIES];
  logic [DATA_WIDTH-1:0] data_tab [ENTRIES];
  logic [DATA_WIDTH-1:0] mask_tab [ENTRIES];

  for (genvar g = 0; g < ENTRIES; g++) begin : g_tab
    assign op_tab[g]   = TABLE_OP[2*g +: 2];
    assign addr_tab[g] = TABLE_ADDR[ADDR_WIDTH*g +: ADDR_WIDTH];
    assign data_tab[g] = TABLE_DATA[DATA_WIDTH*g +: DATA_WIDTH];
    assign mask_tab[g] = TABLE_MASK[DATA_WIDTH*g +: DATA_WIDTH];
  end

  state_t                state_r, state_n;
  logic [8:0]            idx_r, idx_n;
  logic [IW-1:0]         sel_s;
  logic                  first_r;
  logic                  restart_s;
  logic [DATA_WIDTH-1:0] cur_data_r, cur_data_n, cur_mask_r, cur_mask_n;
  logic [DATA_WIDTH-1:0] dly_cnt_r, dly_cnt_n;
  logic [31:0]           poll_cnt_r, poll_cnt_n;
  logic                  awvalid_r, awvalid_n, wvalid_r, wvalid_n, bready_r, bready_n;
  logic                  arvalid_r, arvalid_n, rready_r, rready_n;
  logic                  busy_r, busy_n, done_r, done_n, error_r, error_n;
  logic [7:0]            err_index_r, err_index_n;
  logic [ADDR_WIDTH-1:0] awaddr_r, awaddr_n, araddr_r, araddr_n;
  logic [DATA_WIDTH-1:0] wdata_r, wdata_n;

  assign sel_s = idx_r[IW-1:0];

  // Next-state and next-output decode
  always_comb begin
    state_n     = state_r;
    idx_n       = idx_r;
    cur_data_n  = cur_data_r;
    cur_mask_n  = cur_mask_r;
    dly_cnt_n   = dly_cnt_r;
    poll_cnt_n  = poll_cnt_r;
    awvalid_n   = awvalid_r;
    wvalid_n    = wvalid_r;
    bready_n    = bready_r;
    arvalid_n   = arvalid_r;
    rready_n    = rready_r;
    busy_n      = busy_r;
    done_n      = done_r;
    error_n     = error_r;
    err_index_n = err_index_r;
    awaddr_n    = awaddr_r;
    araddr_n    = araddr_r;
    wdata_n     = wdata_r;
    restart_s   = 1'b0;

    case (state_r)
      S_IDLE: begin
        if (first_r) begin
          restart_s = AUTO_START;
        end else begin
          restart_s = start;
        end
      end
      S_FETCH: begin
        if (idx_r == LAST_IDX) begin
          state_n = S_DONE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end else begin
          cur_data_n = data_tab[sel_s];
          cur_mask_n = mask_tab[sel_s];
          poll_cnt_n = 32'(POLL_LIMIT);
          case (op_tab[sel_s])
            OP_WRITE: begin
              state_n   = S_WR_REQ;
              awvalid_n = 1'b1;
              wvalid_n  = 1'b1;
              awaddr_n  = addr_tab[sel_s];
              wdata_n   = data_tab[sel_s];
            end
            OP_POLL: begin
              state_n   = S_RD_REQ;
              arvalid_n = 1'b1;
              araddr_n  = addr_tab[sel_s];
            end
            OP_DELAY: begin
              state_n   = S_DELAY;
              dly_cnt_n = data_tab[sel_s];
            end
            default: begin
              state_n = S_DONE;
              busy_n  = 1'b0;
              done_n  = 1'b1;
            end
          endcase
        end
      end
      S_WR_REQ: begin
        // AW and W complete independently; leave once neither is pending
        awvalid_n = awvalid_r & ~m_axil_awready;
        wvalid_n  = wvalid_r & ~m_axil_wready;
        if (!awvalid_n && !wvalid_n) begin
          state_n  = S_WR_RESP;
          bready_n = 1'b1;
        end else begin
          state_n = S_WR_REQ;
        end
      end
      S_WR_RESP: begin
        if (m_axil_bvalid) begin
          bready_n = 1'b0;
          if (m_axil_bresp == 2'b00) begin
            state_n = S_FETCH;
            idx_n   = idx_r + 9'd1;
          end else begin
            state_n     = S_ERROR;
            busy_n      = 1'b0;
            error_n     = 1'b1;
            err_index_n = idx_r[7:0];
          end
        end else begin
          state_n = S_WR_RESP;
        end
      end
      S_RD_REQ: begin
        if (m_axil_arready) begin
          state_n   = S_RD_RESP;
          arvalid_n = 1'b0;
          rready_n  = 1'b1;
        end else begin
          state_n = S_RD_REQ;
        end
      end
      S_RD_RESP: begin
        if (m_axil_rvalid) begin
          rready_n = 1'b0;
          if (m_axil_rresp != 2'b00 ||
              (((m_axil_rdata & cur_mask_r) != (cur_data_r & cur_mask_r)) && poll_cnt_r <= 32'd1)) begin
            state_n     = S_ERROR;
            busy_n      = 1'b0;
            error_n     = 1'b1;
            err_index_n = idx_r[7:0];
          end else if ((m_axil_rdata & cur_mask_r) == (cur_data_r & cur_mask_r)) begin
            state_n = S_FETCH;
            idx_n   = idx_r + 9'd1;
          end else begin
            state_n    = S_RD_REQ;
            poll_cnt_n = poll_cnt_r - 32'd1;
            arvalid_n  = 1'b1;
          end
        end else begin
          state_n = S_RD_RESP;
        end
      end
      S_DELAY: begin
        // a zero count still costs one cycle
        if (dly_cnt_r <= ONE_D) begin
          state_n = S_FETCH;
          idx_n   = idx_r + 9'd1;
        end else begin
          dly_cnt_n = dly_cnt_r - ONE_D;
        end
      end
      S_DONE, S_ERROR: begin
        restart_s = start;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    if (restart_s) begin
      state_n = S_FETCH;
      idx_n   = 9'd0;
      busy_n  = 1'b1;
      done_n  = 1'b0;
      error_n = 1'b0;
    end else begin
      restart_s = 1'b0;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      idx_r       <= 9'd0;
      first_r     <= 1'b1;
      cur_data_r  <= '0;
      cur_mask_r  <= '0;
      dly_cnt_r   <= '0;
      poll_cnt_r  <= 32'd0;
      awvalid_r   <= 1'b0;
      wvalid_r    <= 1'b0;
      bready_r    <= 1'b0;
      arvalid_r   <= 1'b0;
      rready_r    <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
      err_index_r <= 8'd0;
      awaddr_r    <= '0;
      araddr_r    <= '0;
      wdata_r     <= '0;
    end else begin
      state_r     <= state_n;
      idx_r       <= idx_n;
      first_r     <= 1'b0;
      cur_data_r  <= cur_data_n;
      cur_mask_r  <= cur_mask_n;
      dly_cnt_r   <= dly_cnt_n;
      poll_cnt_r  <= poll_cnt_n;
      awvalid_r   <= awvalid_n;
      wvalid_r    <= wvalid_n;
      bready_r    <= bready_n;
      arvalid_r   <= arvalid_n;
      rready_r    <= rready_n;
      busy_r      <= busy_n;
      done_r      <= done_n;
      error_r     <= error_n;
      err_index_r <= err_index_n;
      awaddr_r    <= awaddr_n;
      araddr_r    <= araddr_n;
      wdata_r     <= wdata_n;
    end
  end

  assign busy           = busy_r;
  assign done           = done_r;
  assign error          = error_r;
  assign err_index      = err_index_r;
  assign m_axil_awaddr  = awaddr_r;
  assign m_axil_awprot  = 3'b000;
  assign m_axil_awvalid = awvalid_r;
  assign m_axil_wdata   = wdata_r;
  assign m_axil_wstrb   = {STRB_WIDTH{1'b1}};
  assign m_axil_wvalid  = wvalid_r;
  assign m_axil_bready  = bready_r;
  assign m_axil_araddr  = araddr_r;
  assign m_axil_arprot  = 3'b000;
  assign m_axil_arvalid = arvalid_r;
  assign m_axil_rready  = rready_r;

endmodule
